pwm_dac: RTL and testbench

Consumer end of the NCO sample interface. It requests one code per PWM window by pulsing next_sample, and it captures the returned code at the window boundary. It drives a single-bit pulse-width-modulated output whose high time per window equals the captured code. The block sits between the NCO and the audio/LED pin, and it sets the sample rate as clk / CYCLES_PER_WINDOW.

---
 rtl/pwm_dac_if.sv | 17 +
 rtl/pwm_dac.sv | 87 ++++++++
 tb/tb_pwm_dac.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_dac_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pwm_dac_if : sample request/return channel between an NCO and pwm_dac.
// Revision   : 1.0  initial release
// ----------------------------------------------------------------------------
interface pwm_dac_if #(
  parameter int CODE_WIDTH = 10
);
  logic [CODE_WIDTH-1:0] code;
  logic                  next_sample;

  // master: the sample consumer that issues requests
  modport master (output next_sample, input code);
  // slave: the sample producer that answers one cycle after a request
  modport slave  (input next_sample, output code);
endinterface
`default_nettype wire

// File: rtl/pwm_dac.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pwm_dac : one-bit PWM DAC, fetches one code per window via pwm_dac_if.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
module pwm_dac #(
  parameter int CODE_WIDTH        = 10,
  parameter int CYCLES_PER_WINDOW = 1024
) (
  input  wire logic                                 clk,
  input  wire logic                                 rst_n,
  input  wire logic                                 en,
  pwm_dac_if.master                                 bus,
  output logic                                      pwm,
  output logic                                      window_start,
  output logic [$clog2(CYCLES_PER_WINDOW):0]        duty
);

  localparam int CNT_W  = $clog2(CYCLES_PER_WINDOW);
  localparam int DUTY_W = CNT_W + 1;
  localparam int CMP_W  = (CODE_WIDTH > DUTY_W) ? CODE_WIDTH : DUTY_W;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CYCLES_PER_WINDOW - 1);
  localparam logic [CNT_W-1:0]  CNT_REQ  = CNT_W'(CYCLES_PER_WINDOW - 2);
  localparam logic [CMP_W-1:0]  CMP_FULL = CMP_W'(CYCLES_PER_WINDOW);
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(CYCLES_PER_WINDOW);

  logic [CNT_W-1:0]      cnt_q,         cnt_d;
  logic [DUTY_W-1:0]     duty_q,        duty_d;
  logic                  next_sample_q, next_sample_d;
  logic                  en_q,          en_d;

  logic [CODE_WIDTH-1:0] code_s;
  logic [CMP_W-1:0]      code_wide;
  logic [DUTY_W-1:0]     code_clamped;

  assign code_s    = bus.code;
  assign code_wide = CMP_W'(code_s);

  // Codes at or above the window length saturate to a fully-high window.
  always_comb begin
    code_clamped = DUTY_W'(code_wide);
    if (code_wide >= CMP_FULL) begin
      code_clamped = DUTY_MAX;
    end
  end

  always_comb begin
    cnt_d         = cnt_q;
    duty_d        = duty_q;
    next_sample_d = 1'b0;
    en_d          = en;
    if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        duty_d = code_clamped;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
      end
      next_sample_d = (cnt_d == CNT_REQ);
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      duty_q        <= '0;
      next_sample_q <= 1'b0;
      en_q          <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      duty_q        <= duty_d;
      next_sample_q <= next_sample_d;
      en_q          <= en_d;
    end
  end

  assign bus.next_sample = next_sample_q;
  assign pwm             = en_q && ({1'b0, cnt_q} < duty_q);
  // Masked while reset is applied so no spurious window marker leaks out.
  assign window_start    = rst_n && en && (cnt_q == '0);
  assign duty            = duty_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_dac.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pwm_dac : randomized self-checking bench for pwm_dac (16- and 1024-cycle windows).
// Revision   : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_pwm_dac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en16, en1k;
  logic        pwm16, ws16, pwm1k, ws1k;
  logic [4:0]  duty16;
  logic [10:0] duty1k;

  int n_checks = 0;
  int n_pass   = 0;

  pwm_dac_if #(.CODE_WIDTH(10)) if16 ();
  pwm_dac_if #(.CODE_WIDTH(10)) if1k ();

  always #5 clk = ~clk;

  pwm_dac #(.CODE_WIDTH(10), .CYCLES_PER_WINDOW(16)) u_dut16 (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en16),
    .bus          (if16),
    .pwm          (pwm16),
    .window_start (ws16),
    .duty         (duty16)
  );

  pwm_dac #(.CODE_WIDTH(10), .CYCLES_PER_WINDOW(1024)) u_dut1k (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en1k),
    .bus          (if1k),
    .pwm          (pwm1k),
    .window_start (ws1k),
    .duty         (duty1k)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference rule: a window is high for min(code, window length) cycles.
  function automatic int clamp16(input int c);
    return (c >= 16) ? 16 : c;
  endfunction

  // One clock cycle of the 16-cycle DUT: drive code, sample mid-cycle.
  task automatic cyc16(input int c, output bit p, output bit ns, output bit ws, output int d);
    if16.code = 10'(c);
    @(negedge clk);
    p  = pwm16;
    ns = if16.next_sample;
    ws = ws16;
    d  = int'(duty16);
    @(posedge clk);
    #1;
  endtask

  // A whole window; code_next is presented only in the capture cycle when noisy.
  task automatic win16(input string tag, input int code_next, input bit noise,
                       input int exp_high, input int exp_duty);
    int high  = 0;
    int ns_n  = 0;
    int ns_at = -1;
    int ws_n  = 0;
    int ws_at = -1;
    int d0    = 0;
    bit p, ns, ws;
    int d;
    for (int i = 0; i < 16; i++) begin
      cyc16((i == 15 || !noise) ? code_next : int'($urandom_range(0, 1023)), p, ns, ws, d);
      if (i == 0) d0 = d;
      high += int'(p);
      if (ns) begin ns_n++; ns_at = i; end
      if (ws) begin ws_n++; ws_at = i; end
    end
    if (exp_high >= 0) check_eq({tag, ".high"}, high, exp_high);
    check_eq({tag, ".duty"},    d0,    exp_duty);
    check_eq({tag, ".req_pos"}, ns_at, 14);
    check_eq({tag, ".req_cnt"}, ns_n,  1);
    check_eq({tag, ".ws_pos"},  ws_at, 0);
    check_eq({tag, ".ws_cnt"},  ws_n,  1);
  endtask

  task automatic win1k(input string tag, input int c, input int exp_high, input int exp_duty);
    int high  = 0;
    int ns_n  = 0;
    int ns_at = -1;
    int ws_n  = 0;
    int ws_at = -1;
    int d0    = 0;
    if1k.code = 10'(c);
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (i == 0) d0 = int'(duty1k);
      high += int'(pwm1k);
      if (if1k.next_sample) begin ns_n++; ns_at = i; end
      if (ws1k) begin ws_n++; ws_at = i; end
      @(posedge clk);
      #1;
    end
    check_eq({tag, ".high"},    high,  exp_high);
    check_eq({tag, ".duty"},    d0,    exp_duty);
    check_eq({tag, ".req_pos"}, ns_at, 1022);
    check_eq({tag, ".req_cnt"}, ns_n,  1);
    check_eq({tag, ".ws_pos"},  ws_at, 0);
    check_eq({tag, ".ws_cnt"},  ws_n,  1);
  endtask

  initial begin
    int prev;
    int nxt;
    int high;
    int ns_n;
    int hs_codes[5] = '{9, 0, 16, 20, 7};
    bit p, ns, ws;
    int d;

    rst_n     = 1'b0;
    en16      = 1'b0;
    en1k      = 1'b0;
    if16.code = '0;
    if1k.code = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst.pwm16",  int'(pwm16),            0);
    check_eq("rst.req16",  int'(if16.next_sample), 0);
    check_eq("rst.ws16",   int'(ws16),             0);
    check_eq("rst.duty16", int'(duty16),           0);
    check_eq("rst.pwm1k",  int'(pwm1k),            0);
    check_eq("rst.duty1k", int'(duty1k),           0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en16  = 1'b1;

    // Idle window then the first captured code, code held steady.
    win16("w0", 5, 1'b0, 0, 0);
    win16("w1", 3, 1'b0, 5, 5);

    // Handshake sequence 3, 9, 0, 16, 20 with junk outside the capture cycle.
    prev = 3;
    foreach (hs_codes[k]) begin
      win16($sformatf("hs%0d", k), hs_codes[k], 1'b1, clamp16(prev), clamp16(prev));
      prev = hs_codes[k];
    end

    for (int k = 0; k < 100; k++) begin
      nxt = int'($urandom_range(0, 40));
      win16($sformatf("rnd%0d", k), nxt, 1'b1, clamp16(prev), clamp16(prev));
      prev = nxt;
    end

    // Enable drop just before the request cycle, with a fully-high window running.
    win16("pre_drop", 16, 1'b1, clamp16(prev), clamp16(prev));
    high = 0;
    for (int i = 0; i < 13; i++) begin
      cyc16(int'($urandom_range(0, 1023)), p, ns, ws, d);
      high += int'(p);
    end
    check_eq("drop.pre_high", high, 13);
    en16 = 1'b0;
    ns_n = 0;
    cyc16(int'($urandom_range(0, 1023)), p, ns, ws, d);
    ns_n += int'(ns);
    cyc16(int'($urandom_range(0, 1023)), p, ns, ws, d);
    ns_n += int'(ns);
    check_eq("drop.pwm_next", int'(p),  0);
    check_eq("drop.duty",     d,        16);
    high = 0;
    for (int i = 0; i < 4; i++) begin
      cyc16(int'($urandom_range(0, 1023)), p, ns, ws, d);
      high += int'(p) + int'(ws);
      ns_n += int'(ns);
    end
    check_eq("drop.idle_act", high, 0);
    check_eq("drop.req_cnt",  ns_n, 0);
    check_eq("drop.duty_hold", d,   16);
    en16 = 1'b1;
    win16("reen", 4, 1'b1, -1, 16);
    win16("reen2", 10, 1'b1, 4, 4);
    prev = 10;

    // Reset pulse at cnt==7 of a duty-10 window.
    high = 0;
    for (int i = 0; i < 7; i++) begin
      cyc16(int'($urandom_range(0, 1023)), p, ns, ws, d);
      high += int'(p);
    end
    check_eq("rst7.pre_high", high, 7);
    rst_n = 1'b0;
    cyc16(int'($urandom_range(0, 1023)), p, ns, ws, d);
    check_eq("rst7.ws_in_rst", int'(ws), 0);
    rst_n = 1'b1;
    win16("post_rst",  6, 1'b1, 0, 0);
    win16("post_rst2", 0, 1'b1, 6, 6);

    // Boundary codes on the default 1024-cycle window.
    en16 = 1'b0;
    en1k = 1'b1;
    win1k("k_a", 1023, 0,    0);
    win1k("k_b", 1023, 1023, 1023);
    win1k("k_c", 0,    1023, 1023);
    win1k("k_d", 0,    0,    0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
